// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-256 single-block message feeder.
// Contents: FSM state enum, block/digest widths, pad marker byte, and the
// padding function that turns collected message bytes into a padded block.
package sha_pkg;

  localparam int SHA_BLOCK_BITS  = 512;
  localparam int SHA_DIGEST_BITS = 256;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    DRAIN,
    PAD,
    START,
    WAIT,
    DONE
  } shaState_t;

  // Byte k lives at [511-8k -: 8]. Bytes below count are message data and
  // are kept; byte[count] gets the 0x80 marker; the rest up to byte 55 are
  // zeroed; the last 64 bits carry the message length in bits.
  function automatic logic [SHA_BLOCK_BITS-1:0] padBlock(
    input logic [SHA_BLOCK_BITS-1:0] blk,
    input logic [5:0]                count
  );
    logic [SHA_BLOCK_BITS-1:0] r;
    r = blk;
    for (int k = 0; k < 56; k++) begin
      if (k == int'(count))     r[SHA_BLOCK_BITS-1-8*k -: 8] = PAD_BYTE;
      else if (k > int'(count)) r[SHA_BLOCK_BITS-1-8*k -: 8] = 8'h00;
    end
    r[63:0] = {55'd0, count, 3'b000};
    return r;
  endfunction

endpackage

// File: rtl/sha_msg_feeder.sv
// Collects a byte stream into one SHA-256 block, pads it, starts the SHA
// core, waits (bounded) for completion and holds the digest until taken.
// Ports:
//   clk, n_rst                  clock, async active-low reset
//   byte_in/valid/last/ready    message byte stream (valid/ready handshake)
//   msg_empty                   in IDLE, request hash of a zero-length message
//   sha_msg                     padded block to the SHA core
//   begin_computation           one-cycle start strobe
//   enable_computation          core enable (START and WAIT)
//   computation_complete        core done, sampled only in WAIT
//   sha_output                  core digest, captured on completion
//   digest/digest_valid/ready   captured digest handshake
//   length_error                pulse: message longer than MAX_BYTES
//   timeout_error               pulse: core did not finish in time
module sha_msg_feeder import sha_pkg::*; #(
  parameter int MAX_BYTES      = 55,
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [7:0]                 byte_in,
  input  logic                       byte_valid,
  input  logic                       byte_last,
  output logic                       byte_ready,
  input  logic                       msg_empty,
  output logic [SHA_BLOCK_BITS-1:0]  sha_msg,
  output logic                       begin_computation,
  output logic                       enable_computation,
  input  logic                       computation_complete,
  input  logic [SHA_DIGEST_BITS-1:0] sha_output,
  output logic [SHA_DIGEST_BITS-1:0] digest,
  output logic                       digest_valid,
  input  logic                       digest_ready,
  output logic                       length_error,
  output logic                       timeout_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  shaState_t   state;
  logic [5:0]  count;
  logic [TW-1:0] tcnt;
  logic        xfer;

  // Level outputs are straight decodes of the state register.
  assign byte_ready         = (state == IDLE) || (state == COLLECT) || (state == DRAIN);
  assign begin_computation  = (state == START);
  assign enable_computation = (state == START) || (state == WAIT);
  assign digest_valid       = (state == DONE);
  assign xfer               = byte_valid && byte_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      count         <= '0;
      tcnt          <= '0;
      sha_msg       <= '0;
      digest        <= '0;
      length_error  <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      length_error  <= 1'b0;
      timeout_error <= 1'b0;
      case (state)
        IDLE, COLLECT: begin
          if (xfer) begin
            if (int'(count) == MAX_BYTES) begin
              // Block is full; drop the rest. If this byte already ends the
              // message there is nothing left to drain.
              length_error <= 1'b1;
              if (byte_last) begin
                state   <= IDLE;
                sha_msg <= '0;
                count   <= '0;
              end else begin
                state <= DRAIN;
              end
            end else begin
              sha_msg[SHA_BLOCK_BITS-1-8*int'(count) -: 8] <= byte_in;
              count <= count + 6'd1;
              state <= byte_last ? PAD : COLLECT;
            end
          end else if (state == IDLE && msg_empty) begin
            count <= '0;
            state <= PAD;
          end
        end
        DRAIN: begin
          if (xfer && byte_last) begin
            state   <= IDLE;
            sha_msg <= '0;
            count   <= '0;
          end
        end
        PAD: begin
          sha_msg <= padBlock(sha_msg, count);
          state   <= START;
        end
        START: begin
          // tcnt counts cycles since START, so the timeout pulse lands
          // exactly TIMEOUT_CYCLES cycles after the start strobe.
          tcnt  <= TW'(1);
          state <= WAIT;
        end
        WAIT: begin
          // Completion wins over a timeout in the same cycle.
          if (computation_complete) begin
            digest <= sha_output;
            tcnt   <= '0;
            state  <= DONE;
          end else if (int'(tcnt) >= TIMEOUT_CYCLES - 1) begin
            timeout_error <= 1'b1;
            tcnt    <= '0;
            sha_msg <= '0;
            count   <= '0;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        DONE: begin
          if (digest_ready) begin
            sha_msg <= '0;
            count   <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_msg_feeder.sv
// Directed-plus-random bench for sha_msg_feeder. The SHA core is a stub
// driven from here; expected blocks come from a queue-based padding model.
module tb_sha_msg_feeder;

  localparam int MB = 55;
  localparam int TO = 20;

  logic         clk = 1'b0;
  logic         n_rst = 1'b1;
  logic [7:0]   byte_in = '0;
  logic         byte_valid = 1'b0;
  logic         byte_last = 1'b0;
  logic         byte_ready;
  logic         msg_empty = 1'b0;
  logic [511:0] sha_msg;
  logic         begin_computation;
  logic         enable_computation;
  logic         computation_complete = 1'b0;
  logic [255:0] sha_output = '0;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ready = 1'b0;
  logic         length_error;
  logic         timeout_error;

  int total = 0;
  int bad   = 0;
  logic [7:0] msgQ[$];

  always #5 clk = ~clk;

  sha_msg_feeder #(.MAX_BYTES(MB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_rst(n_rst),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready),
    .msg_empty(msg_empty), .sha_msg(sha_msg),
    .begin_computation(begin_computation), .enable_computation(enable_computation),
    .computation_complete(computation_complete), .sha_output(sha_output),
    .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready),
    .length_error(length_error), .timeout_error(timeout_error)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference padding: message bytes big-endian, 0x80 marker, bit length.
  function automatic logic [511:0] padRef();
    logic [511:0] blk;
    int n;
    n = msgQ.size();
    blk = '0;
    foreach (msgQ[k]) blk[511-8*k -: 8] = msgQ[k];
    blk[511-8*n -: 8] = 8'h80;
    blk[63:0] = 64'(n * 8);
    return blk;
  endfunction

  function automatic logic [255:0] rndDig();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic loadRandom(input int n);
    msgQ.delete();
    for (int i = 0; i < n; i++) msgQ.push_back(8'($urandom));
  endtask

  // Called at a negedge; returns at the negedge after the last byte transfer.
  task automatic sendMsg(input bit withEmpty);
    int n;
    bit ovf;
    n = msgQ.size();
    ovf = (n > MB);
    for (int k = 0; k < n; k++) begin
      byte_in = msgQ[k]; byte_valid = 1'b1; byte_last = (k == n - 1);
      msg_empty = withEmpty && (k == 0);
      chk("ready_before", byte_ready, 1);
      @(negedge clk);
      byte_valid = 1'b0; byte_last = 1'b0; msg_empty = 1'b0; byte_in = 8'($urandom);
      chk("len_err", length_error, (k == MB));
      if (k < n - 1) begin
        chk("ready_mid", byte_ready, 1);
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          chk("len_err_gap", length_error, 0);
        end
      end else begin
        chk("ready_after_last", byte_ready, ovf);
      end
    end
  endtask

  // Entered at the PAD-cycle negedge.
  task automatic doHash(input logic [511:0] expBlk, input int waitCyc, input int holdCyc);
    logic [255:0] dig;
    dig = rndDig();
    @(negedge clk);
    chk("begin_hi", begin_computation, 1);
    chk("en_start", enable_computation, 1);
    chk("blk", sha_msg, expBlk);
    chk("ready_start", byte_ready, 0);
    @(negedge clk);
    chk("begin_one_cycle", begin_computation, 0);
    chk("en_wait", enable_computation, 1);
    repeat (waitCyc) begin
      digest_ready = 1'b1;
      @(negedge clk);
      digest_ready = 1'b0;
      chk("blk_stable", sha_msg, expBlk);
      chk("dv_in_wait", digest_valid, 0);
      chk("to_in_wait", timeout_error, 0);
    end
    computation_complete = 1'b1; sha_output = dig;
    @(negedge clk);
    computation_complete = 1'b0; sha_output = rndDig();
    chk("dv_done", digest_valid, 1);
    chk("digest", digest, dig);
    chk("en_done", enable_computation, 0);
    repeat (holdCyc) begin
      computation_complete = 1'b1;
      @(negedge clk);
      computation_complete = 1'b0;
      chk("dv_hold", digest_valid, 1);
      chk("digest_hold", digest, dig);
      chk("ready_hold", byte_ready, 0);
    end
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    chk("dv_cleared", digest_valid, 0);
    chk("ready_idle", byte_ready, 1);
    chk("blk_cleared", sha_msg, 0);
  endtask

  task automatic doTimeout(input logic [511:0] expBlk);
    @(negedge clk);
    chk("to_begin", begin_computation, 1);
    chk("to_blk", sha_msg, expBlk);
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      if (c < TO) begin
        chk("to_early", timeout_error, 0);
        chk("to_en", enable_computation, 1);
      end else begin
        chk("to_pulse", timeout_error, 1);
        chk("to_en_off", enable_computation, 0);
        chk("to_dv", digest_valid, 0);
        chk("to_ready", byte_ready, 1);
        chk("to_blk_clr", sha_msg, 0);
      end
    end
    computation_complete = 1'b1;
    @(negedge clk);
    computation_complete = 1'b0;
    chk("to_one_pulse", timeout_error, 0);
    chk("to_late_cc", digest_valid, 0);
    chk("to_no_begin", begin_computation, 0);
  endtask

  task automatic chkResetOutputs(input string tag);
    chk({tag, "_msg"}, sha_msg, 0);
    chk({tag, "_dig"}, digest, 0);
    chk({tag, "_dv"}, digest_valid, 0);
    chk({tag, "_begin"}, begin_computation, 0);
    chk({tag, "_en"}, enable_computation, 0);
    chk({tag, "_le"}, length_error, 0);
    chk({tag, "_te"}, timeout_error, 0);
    chk({tag, "_ready"}, byte_ready, 1);
  endtask

  initial begin
    #1 n_rst = 1'b0;
    repeat (2) @(negedge clk);
    chkResetOutputs("rst");
    n_rst = 1'b1;

    // "abc" straight out of reset, first edge takes a byte.
    msgQ = '{8'h61, 8'h62, 8'h63};
    sendMsg(1'b0);
    doHash({32'h61626380, 416'h0, 64'h18}, 2, 1);

    // Zero-length message, digest held 10 cycles.
    msg_empty = 1'b1;
    @(negedge clk);
    msg_empty = 1'b0;
    chk("empty_pad_ready", byte_ready, 0);
    doHash({8'h80, 504'h0}, 3, 10);

    // Length boundaries and random lengths; one with a simultaneous msg_empty.
    loadRandom(1);   sendMsg(1'b0); doHash(padRef(), 0, 0);
    loadRandom(MB);  sendMsg(1'b0); doHash(padRef(), TO - 2, 2);
    loadRandom(7);   sendMsg(1'b1); doHash(padRef(), $urandom_range(0, TO - 2), 1);
    for (int t = 0; t < 3; t++) begin
      loadRandom($urandom_range(1, MB));
      sendMsg(1'b0);
      doHash(padRef(), $urandom_range(0, TO - 2), $urandom_range(0, 3));
    end

    // Over-length message drains without starting the core.
    loadRandom(MB + 4);
    sendMsg(1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("ovf_no_begin", begin_computation, 0);
      chk("ovf_idle_ready", byte_ready, 1);
      chk("ovf_blk_clr", sha_msg, 0);
    end
    msgQ = '{8'h61, 8'h62, 8'h63};
    sendMsg(1'b0);
    doHash({32'h61626380, 416'h0, 64'h18}, 1, 0);

    // Core never completes.
    loadRandom($urandom_range(1, MB));
    sendMsg(1'b0);
    doTimeout(padRef());

    // Reset in the middle of WAIT, then a clean "abc".
    msgQ = '{8'h61, 8'h62, 8'h63};
    sendMsg(1'b0);
    @(negedge clk);
    chk("mid_begin", begin_computation, 1);
    repeat (2) @(negedge clk);
    #2 n_rst = 1'b0;
    #1 chkResetOutputs("midrst");
    @(negedge clk);
    n_rst = 1'b1;
    sendMsg(1'b0);
    doHash({32'h61626380, 416'h0, 64'h18}, 4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha_msg_feeder.md
SHA_MSG_FEEDER -- requirements
Module: sha_msg_feeder

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 55, the largest message length in bytes that fits one padded block.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100, the maximum cycles to wait for computation_complete.
REQ-003 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port n_rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port byte_in  in  8  message byte.
REQ-006 SHALL have port byte_valid  in  1  byte_in valid.
REQ-007 SHALL have port byte_last  in  1  marks final byte of message, qualified by byte_valid.
REQ-008 SHALL have port byte_ready  out  1  feeder accepts byte this cycle.
REQ-009 SHALL have port msg_empty  in  1  pulse in IDLE to hash a zero-length message.
REQ-010 SHALL have port sha_msg  out  512  padded block, drives SHAcomputationalBlock inputSHAMsg.
REQ-011 SHALL have port begin_computation  out  1  one-cycle start strobe to SHA core.
REQ-012 SHALL have port enable_computation  out  1  SHA core enable.
REQ-013 SHALL have port computation_complete  in  1  SHA core done.
REQ-014 SHALL have port sha_output  in  256  SHA core digest.
REQ-015 SHALL have port digest  out  256  captured digest.
REQ-016 SHALL have port digest_valid  out  1  digest held valid.
REQ-017 SHALL have port digest_ready  in  1  consumer takes digest.
REQ-018 SHALL have port length_error  out  1  one-cycle pulse, message exceeded MAX_BYTES.
REQ-019 SHALL have port timeout_error  out  1  one-cycle pulse, core did not complete in TIMEOUT_CYCLES.

Function
REQ-020 SHALL implement FSM states IDLE, COLLECT, DRAIN, PAD, START, WAIT, DONE.
REQ-021 A transfer SHALL occur when byte_valid and byte_ready are both high on a rising edge.
REQ-022 byte_ready SHALL be 1 in IDLE, COLLECT, and DRAIN, and 0 otherwise.
REQ-023 IDLE SHALL go to COLLECT on a transfer without byte_last, to PAD on a transfer with byte_last, and to PAD with count 0 on msg_empty; a transfer SHALL take priority over a simultaneous msg_empty.
REQ-024 Byte k (0-based) SHALL be stored at sha_msg bits [511-8k -: 8], big-endian; a byte count register (6 bits) SHALL increment per transfer.
REQ-025 A transfer that would make the count exceed MAX_BYTES SHALL pulse length_error once and move the FSM to DRAIN; DRAIN SHALL discard bytes until a byte_last transfer, then return to IDLE.
REQ-026 PAD SHALL last 1 cycle: byte[count]=0x80, bytes count+1..55 = 0x00, bits [63:0] = count*8; then go to START.
REQ-027 START SHALL last 1 cycle with begin_computation=1 and enable_computation=1, then go to WAIT.
REQ-028 WAIT SHALL hold enable_computation=1 and sha_msg stable, and increment a timeout counter each cycle.
REQ-029 In WAIT, computation_complete=1 SHALL capture sha_output into digest and go to DONE; if the counter reaches TIMEOUT_CYCLES first, timeout_error SHALL pulse and the FSM SHALL go to IDLE.
REQ-030 computation_complete asserted in the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as completion.
REQ-031 DONE SHALL hold digest_valid=1 and digest stable until digest_ready=1, then go to IDLE; enable_computation SHALL be 0 in DONE.
REQ-032 digest_ready SHALL be ignored outside DONE; computation_complete SHALL be ignored outside WAIT.
REQ-033 sha_msg SHALL be cleared to 0 on entry to IDLE.

Reset
REQ-034 Assertion of n_rst=0 SHALL immediately force IDLE, count=0, timeout counter=0, sha_msg=0, digest=0, and all strobes/valids=0, including mid-message or mid-WAIT.
REQ-035 After reset release, the first clock edge SHALL be able to accept a byte.

Structure
REQ-036 Package sha_pkg SHALL hold the state enum, SHA_BLOCK_BITS=512, SHA_DIGEST_BITS=256, and PAD_BYTE=8'h80.
REQ-037 The design SHALL be a single module with no sub-modules; the padding function SHALL be a function in sha_pkg.

Verification
REQ-038 Reset, then msg_empty pulse -> sha_msg=0x80 followed by 63 zero bytes; with SHAcomputationalBlock attached, digest=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-039 Bytes "abc" (last on 'c') -> sha_msg=61626380...0018; digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; begin_computation high exactly 1 cycle.
REQ-040 56-byte message -> length_error pulses once on byte 56, remaining bytes are accepted, no begin_computation occurs, and the FSM returns to IDLE after byte_last.
REQ-041 Stub core that never completes -> timeout_error pulses TIMEOUT_CYCLES cycles after START, and digest_valid stays 0.
REQ-042 digest_ready held 0 for 10 cycles -> digest_valid and digest stay stable and byte_ready=0; digest_ready=1 -> IDLE the next cycle.
REQ-043 n_rst pulsed low during WAIT -> all outputs are 0 immediately, and a following "abc" hashes correctly.
